// File: rtl/vend_txn_ctrl_if.sv
// Bus bundle between the vending transaction controller and its surroundings:
// coin/selection front panel, item dispenser and change hopper.
interface vend_txn_ctrl_if;
  logic       coin_n;
  logic       coin_d;
  logic       coin_q;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack;
  logic       chg_req;
  logic       chg_ack;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       err_insuff;

  // master: front panel / dispenser / hopper side
  modport master (
    output coin_n, coin_d, coin_q, sel_valid, sel, cancel, disp_ack, chg_ack,
    input  disp_req, disp_item, chg_req, credit, busy, coin_reject, err_insuff
  );

  // slave: the transaction controller
  modport slave (
    input  coin_n, coin_d, coin_q, sel_valid, sel, cancel, disp_ack, chg_ack,
    output disp_req, disp_item, chg_req, credit, busy, coin_reject, err_insuff
  );
endinterface

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: nickel-unit credit accumulation, price check,
// dispense handshake and one-nickel-at-a-time change/refund handshake.
//
//   state  | meaning
//   IDLE   | no credit, waiting for the first valid coin
//   CREDIT | holding credit; accepts coins, selection, cancel; inactivity timer runs
//   VEND   | disp_req high, waiting for disp_ack
//   CHANGE | chg_req high while credit > 0, one nickel per chg_ack
module vend_txn_ctrl #(
  parameter int unsigned PRICE_PENCIL = 2,
  parameter int unsigned PRICE_ERASER = 4,
  parameter int unsigned PRICE_PEN    = 6,
  parameter int unsigned MAX_CREDIT   = 20,
  parameter int unsigned TIMEOUT_CYC  = 1000
) (
  input logic            clk,
  input logic            reset,
  vend_txn_ctrl_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [5:0]    credit_q;
  logic          disp_req_q;
  logic [1:0]    disp_item_q;
  logic          chg_req_q;
  logic          busy_q;
  logic          coin_reject_q;
  logic          err_insuff_q;

  logic       coin_any;
  logic       coin_one;
  logic [2:0] coin_val;
  logic [5:0] price;
  logic       coin_fits;
  logic       coin_ok;
  logic       sel_hit;
  logic       sel_ok;
  logic       sel_low;
  logic       tmo;

  always_comb begin
    coin_any  = bus.coin_n | bus.coin_d | bus.coin_q;
    coin_one  = ({2'b00, bus.coin_n} + {2'b00, bus.coin_d} + {2'b00, bus.coin_q}) == 3'd1;
    coin_val  = bus.coin_n ? 3'd1 : (bus.coin_d ? 3'd2 : 3'd5);
    case (bus.sel)
      2'b01:   price = 6'(PRICE_PENCIL);
      2'b10:   price = 6'(PRICE_ERASER);
      2'b11:   price = 6'(PRICE_PEN);
      default: price = 6'd0;
    endcase
    coin_fits = ({1'b0, credit_q} + {4'b0000, coin_val}) <= 7'(MAX_CREDIT);
    coin_ok   = coin_one && coin_fits;
    sel_hit   = bus.sel_valid && (bus.sel != 2'b00);
    sel_ok    = sel_hit && (credit_q >= price);
    sel_low   = sel_hit && (credit_q < price);
    tmo       = (timer == TMO_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      disp_item_q   <= 2'b00;
      chg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      err_insuff_q  <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      err_insuff_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_ok) begin
            credit_q <= {3'b000, coin_val};
            timer    <= '0;
            state    <= CREDIT;
          end else begin
            coin_reject_q <= coin_any;
          end
        end
        CREDIT: begin
          if (bus.cancel) begin
            coin_reject_q <= coin_any;
            chg_req_q     <= (credit_q != 6'd0);
            busy_q        <= 1'b1;
            state         <= CHANGE;
          end else if (sel_ok) begin
            coin_reject_q <= coin_any;
            disp_item_q   <= bus.sel;
            credit_q      <= credit_q - price;
            disp_req_q    <= 1'b1;
            busy_q        <= 1'b1;
            state         <= VEND;
          end else begin
            err_insuff_q <= sel_low;
            if (coin_ok) begin
              credit_q <= credit_q + {3'b000, coin_val};
              timer    <= '0;
            end else begin
              coin_reject_q <= coin_any;
              // a rejected coin is not activity; only sel_valid restarts the timer here
              if (bus.sel_valid) begin
                timer <= '0;
              end else if (tmo) begin
                chg_req_q <= (credit_q != 6'd0);
                busy_q    <= 1'b1;
                state     <= CHANGE;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_reject_q <= coin_any;
          if (bus.disp_ack) begin
            disp_req_q <= 1'b0;
            if (credit_q == 6'd0) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              chg_req_q <= 1'b1;
              state     <= CHANGE;
            end
          end
        end
        CHANGE: begin
          coin_reject_q <= coin_any;
          if (credit_q == 6'd0) begin
            chg_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else if (bus.chg_ack) begin
            credit_q <= credit_q - 6'd1;
            if (credit_q == 6'd1) begin
              chg_req_q <= 1'b0;
              busy_q    <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.credit      = credit_q;
  assign bus.disp_req    = disp_req_q;
  assign bus.disp_item   = disp_item_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.err_insuff  = err_insuff_q;

endmodule
